// File: rtl/tb_pkg.sv
// rtl/tb_pkg.sv - shared widths, opcodes and index-width helpers for the select datapath
package tb_pkg;

  localparam int NCORES_DEF = 4;
  localparam int AW_DEF     = 16;
  localparam int DW_DEF     = 16;

  // Index width wide enough to name any requester; never below one bit.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  localparam int IDXW = idx_width(NCORES_DEF);

  // Instruction opcodes executed by the select stages.
  typedef enum logic [1:0] {
    PLUS  = 2'd0,
    MINUS = 2'd1,
    BRZ   = 2'd2
  } opcode_e;

endpackage

// File: rtl/rr_pick.sv
// rtl/rr_pick.sv - combinational round-robin priority picker
module rr_pick #(
  parameter int NCORES = 4,
  parameter int IW     = 2
) (
  input  logic [NCORES-1:0] eligible,
  input  logic [IW-1:0]     rr,
  output logic [NCORES-1:0] win_oh,
  output logic [IW-1:0]     win_idx,
  output logic              win_any
);

  logic [IW:0]   cand;
  logic [IW-1:0] cidx;

  // Scan from rr upward with wrap; the first eligible index wins.
  always_comb begin
    win_oh  = '0;
    win_idx = '0;
    win_any = 1'b0;
    cand    = '0;
    cidx    = '0;
    for (int off = 0; off < NCORES; off++) begin
      cand = {1'b0, rr} + (IW+1)'(off);
      if (cand >= (IW+1)'(NCORES)) begin
        cand = cand - (IW+1)'(NCORES);
      end
      cidx = cand[IW-1:0];
      if (!win_any && eligible[cidx]) begin
        win_any      = 1'b1;
        win_idx      = cidx;
        win_oh[cidx] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/mem_read_arbiter.sv
// rtl/mem_read_arbiter.sv - round-robin arbiter sharing one memory read port among select units
module mem_read_arbiter
  import tb_pkg::*;
#(
  parameter int NCORES = NCORES_DEF,
  parameter int AW     = AW_DEF,
  parameter int DW     = DW_DEF,
  parameter int LAT    = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NCORES-1:0]    req,
  input  logic [NCORES*AW-1:0] addr,
  output logic [NCORES-1:0]    grant,
  output logic                 mem_en,
  output logic [AW-1:0]        mem_addr,
  input  logic [DW-1:0]        mem_rdata,
  output logic [NCORES-1:0]    rd_valid,
  output logic [DW-1:0]        rd_data,
  output logic [NCORES-1:0]    busy
);

  localparam int IW = idx_width(NCORES);

  logic [IW-1:0]            rr_q, rr_d;
  logic [NCORES-1:0]        busy_q, busy_d;
  logic [LAT-1:0]           pipe_vld_q, pipe_vld_d;
  logic [LAT-1:0][IW-1:0]   pipe_idx_q, pipe_idx_d;

  logic [NCORES-1:0]        eligible;
  logic [NCORES-1:0]        win_oh;
  logic [IW-1:0]            win_idx;
  logic                     win_any;
  logic [NCORES-1:0]        ret_oh;

  // A requester with a read in flight is masked until its busy flag drops.
  assign eligible = req & ~busy_q;

  rr_pick #(
    .NCORES (NCORES),
    .IW     (IW)
  ) u_rr_pick (
    .eligible (eligible),
    .rr       (rr_q),
    .win_oh   (win_oh),
    .win_idx  (win_idx),
    .win_any  (win_any)
  );

  // Drive the memory port from the winner; address is forced to zero when idle.
  always_comb begin
    grant    = win_oh;
    mem_en   = win_any;
    mem_addr = '0;
    for (int i = 0; i < NCORES; i++) begin
      if (win_oh[i]) begin
        mem_addr = addr[i*AW +: AW];
      end
    end
  end

  // Decode the last pipeline stage into the owner of the returning word.
  always_comb begin
    ret_oh = '0;
    if (pipe_vld_q[LAT-1]) begin
      ret_oh[pipe_idx_q[LAT-1]] = 1'b1;
    end
  end

  assign rd_valid = ret_oh;
  assign rd_data  = mem_rdata;
  assign busy     = busy_q;

  // Next-state: busy clears on return and sets on grant; pipeline shifts every cycle.
  always_comb begin
    busy_d = (busy_q & ~ret_oh) | win_oh;
    rr_d   = rr_q;
    if (win_any) begin
      rr_d = (win_idx == IW'(NCORES-1)) ? '0 : win_idx + IW'(1);
    end
    pipe_vld_d    = '0;
    pipe_idx_d    = '0;
    pipe_vld_d[0] = mem_en;
    pipe_idx_d[0] = win_idx;
    for (int s = 1; s < LAT; s++) begin
      pipe_vld_d[s] = pipe_vld_q[s-1];
      pipe_idx_d[s] = pipe_idx_q[s-1];
    end
  end

  // State registers; reset drops every in-flight read so none ever returns.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_q       <= '0;
      busy_q     <= '0;
      pipe_vld_q <= '0;
      pipe_idx_q <= '0;
    end else begin
      rr_q       <= rr_d;
      busy_q     <= busy_d;
      pipe_vld_q <= pipe_vld_d;
      pipe_idx_q <= pipe_idx_d;
    end
  end

endmodule

// File: tb/tb_mem_read_arbiter.sv
// tb/tb_mem_read_arbiter.sv - self-checking bench for mem_read_arbiter
module tb_mem_read_arbiter;

  localparam int NC  = 4;
  localparam int AW  = 16;
  localparam int DW  = 16;
  localparam int LAT = 2;

  logic              clk;
  logic              rst_n;
  logic [NC-1:0]     req;
  logic [NC*AW-1:0]  addr;
  logic [NC-1:0]     grant;
  logic              mem_en;
  logic [AW-1:0]     mem_addr;
  logic [DW-1:0]     mem_rdata;
  logic [NC-1:0]     rd_valid;
  logic [DW-1:0]     rd_data;
  logic [NC-1:0]     busy;

  int n_tests = 0;
  int n_fail  = 0;

  mem_read_arbiter #(
    .NCORES (NC),
    .AW     (AW),
    .DW     (DW),
    .LAT    (LAT)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req       (req),
    .addr      (addr),
    .grant     (grant),
    .mem_en    (mem_en),
    .mem_addr  (mem_addr),
    .mem_rdata (mem_rdata),
    .rd_valid  (rd_valid),
    .rd_data   (rd_data),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, got, exp, $time);
    end
  endtask

  // Reference model: a read issued in cycle t keeps its requester busy in
  // cycles t+1..t+LAT and returns in cycle t+LAT.
  int            issue_t [NC];
  int            rr_m;
  int            cyc;
  int            m_w;
  int            m_j;
  logic [NC-1:0] m_busy, m_elig, m_grant, m_rv;
  logic [AW-1:0] m_addr;

  always @(negedge clk) begin
    if (!rst_n) begin
      chk("rst_grant",    32'(grant),    32'd0);
      chk("rst_mem_en",   32'(mem_en),   32'd0);
      chk("rst_mem_addr", 32'(mem_addr), 32'd0);
      chk("rst_rd_valid", 32'(rd_valid), 32'd0);
      chk("rst_busy",     32'(busy),     32'd0);
      for (int i = 0; i < NC; i++) issue_t[i] = -1;
      rr_m = 0;
    end else begin
      for (int i = 0; i < NC; i++) begin
        m_busy[i] = (issue_t[i] >= 0) && (cyc > issue_t[i]) && (cyc <= issue_t[i] + LAT);
        m_rv[i]   = (issue_t[i] >= 0) && (cyc == issue_t[i] + LAT);
      end
      m_elig = req & ~m_busy;
      m_w = -1;
      for (int k = 0; k < NC; k++) begin
        m_j = (rr_m + k) % NC;
        if (m_w < 0 && m_elig[m_j]) m_w = m_j;
      end
      m_grant = '0;
      m_addr  = '0;
      if (m_w >= 0) begin
        m_grant[m_w] = 1'b1;
        m_addr       = addr[m_w*AW +: AW];
      end
      chk("m_grant",    32'(grant),    32'(m_grant));
      chk("m_mem_en",   32'(mem_en),   32'(m_w >= 0));
      chk("m_mem_addr", 32'(mem_addr), 32'(m_addr));
      chk("m_busy",     32'(busy),     32'(m_busy));
      chk("m_rd_valid", 32'(rd_valid), 32'(m_rv));
      if (|m_rv) chk("m_rd_data", 32'(rd_data), 32'(mem_rdata));
      if (m_w >= 0) begin
        issue_t[m_w] = cyc;
        rr_m = (m_w + 1) % NC;
      end
    end
    cyc++;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic do_reset();
    tick();
    rst_n = 1'b0;
    req   = '0;
    settle();
    chk("reset_grant",    32'(grant),    32'd0);
    chk("reset_mem_en",   32'(mem_en),   32'd0);
    chk("reset_mem_addr", 32'(mem_addr), 32'd0);
    chk("reset_rd_valid", 32'(rd_valid), 32'd0);
    chk("reset_busy",     32'(busy),     32'd0);
    tick();
    rst_n = 1'b1;
    req   = '0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  logic [NC-1:0] sup_exp [4];

  initial begin
    rst_n     = 1'b0;
    req       = '0;
    addr      = '0;
    mem_rdata = '0;
    cyc       = 0;
    rr_m      = 0;
    for (int i = 0; i < NC; i++) issue_t[i] = -1;

    // Single request
    do_reset();
    tick();
    req  = 4'b0001;
    addr = {16'h4444, 16'h3333, 16'h2222, 16'h0010};
    settle();
    chk("single_grant",    32'(grant),    32'h1);
    chk("single_mem_en",   32'(mem_en),   32'h1);
    chk("single_mem_addr", 32'(mem_addr), 32'h0010);
    tick();
    req = '0;
    settle();
    chk("single_busy1", 32'(busy),     32'h1);
    chk("single_rv1",   32'(rd_valid), 32'h0);
    tick();
    mem_rdata = 16'hBEEF;
    settle();
    chk("single_rv2",   32'(rd_valid), 32'h1);
    chk("single_data",  32'(rd_data),  32'hBEEF);
    chk("single_busy2", 32'(busy),     32'h1);
    tick();
    mem_rdata = 16'h0000;
    settle();
    chk("single_busy3", 32'(busy),     32'h0);
    chk("single_rv3",   32'(rd_valid), 32'h0);

    // Round-robin with all requesting
    do_reset();
    for (int c = 0; c < 8; c++) begin
      tick();
      req  = 4'hF;
      addr = {$urandom(), $urandom()};
      settle();
      chk("rr_grant", 32'(grant), 32'(1 << (c % 4)));
    end
    tick();
    req = '0;

    // Busy suppression on requester 1
    sup_exp[0] = 4'b0010;
    sup_exp[1] = 4'b0000;
    sup_exp[2] = 4'b0000;
    sup_exp[3] = 4'b0010;
    do_reset();
    for (int c = 0; c < 4; c++) begin
      tick();
      req = 4'b0010;
      settle();
      chk("sup_grant",  32'(grant),  32'(sup_exp[c]));
      chk("sup_mem_en", 32'(mem_en), 32'(|sup_exp[c]));
    end
    tick();
    req = '0;

    // Wrap-around from rr=3
    do_reset();
    tick();
    req = 4'b0100;
    settle();
    chk("wrap_g2", 32'(grant), 32'b0100);
    tick();
    req = 4'b1001;
    settle();
    chk("wrap_g3", 32'(grant), 32'b1000);
    tick();
    settle();
    chk("wrap_g0", 32'(grant), 32'b0001);
    tick();
    req = '0;

    // Reset with two reads in flight
    do_reset();
    tick();
    req = 4'b0001;
    tick();
    req = 4'b0010;
    tick();
    rst_n = 1'b0;
    req   = '0;
    settle();
    chk("midrst_busy", 32'(busy), 32'h0);
    tick();
    rst_n = 1'b1;
    for (int c = 0; c < 4; c++) begin
      tick();
      settle();
      chk("midrst_rv",   32'(rd_valid), 32'h0);
      chk("midrst_busy", 32'(busy),     32'h0);
    end
    tick();
    req = 4'hF;
    settle();
    chk("midrst_rr0", 32'(grant), 32'h1);
    tick();
    req = '0;

    // Idle keeps outputs quiet and rr unchanged
    do_reset();
    tick();
    req = 4'b0001;
    tick();
    req = '0;
    tick();
    tick();
    for (int c = 0; c < 10; c++) begin
      tick();
      addr = {$urandom(), $urandom()};
      settle();
      chk("idle_grant",    32'(grant),    32'h0);
      chk("idle_mem_en",   32'(mem_en),   32'h0);
      chk("idle_mem_addr", 32'(mem_addr), 32'h0);
      chk("idle_rd_valid", 32'(rd_valid), 32'h0);
    end
    tick();
    req = 4'hF;
    settle();
    chk("idle_rr_kept", 32'(grant), 32'b0010);
    tick();
    req = '0;

    // Randomized traffic with occasional asynchronous resets
    for (int c = 0; c < 3000; c++) begin
      tick();
      addr      = {$urandom(), $urandom()};
      mem_rdata = DW'($urandom());
      if ($urandom_range(0, 199) == 0) begin
        rst_n = 1'b0;
        req   = '0;
      end else begin
        rst_n = 1'b1;
        if ($urandom_range(0, 1) == 0) req = NC'($urandom()) | NC'($urandom());
        else                           req = NC'($urandom()) & NC'($urandom());
      end
    end
    tick();
    rst_n = 1'b1;
    req   = '0;
    repeat (4) tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_read_arbiter.md
# mem_read_arbiter

Shares the single data-memory read port among the `NCORES` select units. Each select unit raises a one-cycle read request for the cell at its pointer and expects the data back a fixed number of cycles later. The arbiter grants one requester per cycle in round-robin order, drives the memory port, and tracks every in-flight read so the returning word reaches the right unit. It sits between the select stages and the data memory, and replaces the shared `mem_en` daisy-chain.

## Interface

Parameters:
- `NCORES`, 4: number of requesters (select units); ≥2.
- `AW`, 16: address width.
- `DW`, 16: data width.
- `LAT`, 2: memory read latency in cycles, from `mem_en` to `mem_rdata` valid; ≥1.

Ports:
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst_n`  in  1  reset, asynchronous assert, active-low (already decided).
- `req`  in  NCORES  per-requester read request, sampled every cycle.
- `addr`  in  NCORES*AW  per-requester address; requester i occupies bits `[i*AW +: AW]`.
- `grant`  out  NCORES  combinational, one-hot or zero; request accepted this cycle.
- `mem_en`  out  1  combinational memory read enable.
- `mem_addr`  out  AW  combinational address of the granted requester; 0 when idle.
- `mem_rdata`  in  DW  memory read data, valid `LAT` cycles after `mem_en`.
- `rd_valid`  out  NCORES  registered-path one-hot; return data belongs to requester i.
- `rd_data`  out  DW  `mem_rdata` broadcast to all requesters.
- `busy`  out  NCORES  requester i has a read outstanding.

## Operation

- Eligibility:
  - Requester i is eligible when `req[i]` is high and `busy[i]` is low.
  - Each requester has at most one outstanding read.
  - A request from a busy requester is ignored and not queued; the requester keeps `req` high until granted.
- Arbitration:
  - Round-robin over eligible requesters, starting at pointer `rr`.
  - The winner is the first eligible index at or after `rr`, wrapping modulo `NCORES`.
  - At most one grant per cycle.
  - On a grant to index w, `rr` becomes (w+1) mod `NCORES`.
  - `rr` is unchanged on idle cycles.
- Issue:
  - On a grant to w: `mem_en`=1, `mem_addr`=addr[w], `grant[w]`=1.
  - `busy[w]` sets at the next edge.
- Tracking:
  - A `LAT`-deep shift pipeline carries {valid, index}. Stage 0 is loaded with {`mem_en`, w}.
  - When the last stage is valid with index k:
    - `rd_valid[k]`=1 and `rd_data`=`mem_rdata` that cycle.
    - `busy[k]` clears at the following edge.
- Simultaneous events:
  - `busy[k]` clearing and a new request from k in the same cycle: k is not eligible in that cycle.
  - k is eligible from the next cycle.
  - This gives a minimum re-issue spacing per requester of `LAT`+1 cycles.
- Reset:
  - Values: `rr`=0, all pipeline valids=0, `busy`=0.
  - Therefore `grant`=0, `mem_en`=0, `mem_addr`=0, `rd_valid`=0.
  - `rd_data` follows `mem_rdata` and has no reset value.
  - Reset asserted mid-flight discards all in-flight reads; their `rd_valid` never fires.
- No cancellation input exists. A requester that has branched ignores its returning `rd_valid`.

## Timing

- Request to grant: same cycle (combinational) when eligible.
- Grant to `rd_valid`: exactly `LAT` cycles.
- Throughput:
  - One read per cycle across all requesters.
  - One read per `LAT`+1 cycles per requester.
- Fairness: with all requesters continuously eligible, every requester is granted within `NCORES` cycles.
- Combinational path: `req`, `busy`, `rr` → `grant`/`mem_en`/`mem_addr`.
  - `busy` and `rr` are flops.
  - No path from `mem_rdata` to `grant`.

## Structure

- Shared package `tb_pkg`:
  - Widths `AW`/`DW` defaults.
  - Opcode constants (PLUS, MINUS, BRZ) used by the select stages.
  - `clog2`-based index width constant `IDXW`.
- Sub-module `rr_pick`: combinational round-robin priority picker.
  - Inputs: `eligible[NCORES]`, `rr`.
  - Outputs: one-hot winner and binary index.
- The latency pipeline and busy flags stay in the top module.

## Test plan

- **Single request:** reset, then `req`=0001, `addr[0]`=0x0010.
  - Same cycle: `grant`=0001, `mem_en`=1, `mem_addr`=0x0010.
  - Two cycles later: `rd_valid`=0001 with `mem_rdata`=0xBEEF seen on `rd_data`.
  - `busy[0]` high for exactly 2 cycles.
- **Round-robin:** `req`=1111 held for 8 cycles, `LAT`=2.
  - Grants 0,1,2,3 in cycles 0–3.
  - Cycle 4: requester 0 is eligible again (`busy` cleared after its return), so grant 0.
  - No grant is repeated while `busy`.
- **Busy suppression:** requester 1 is granted, then holds `req[1]`=1 with no other requesters.
  - Regrants at cycle `LAT`+1 = 3, not earlier; `mem_en`=0 in cycles 1–2.
- **Wrap-around:** `rr`=3 after granting 2; `req`=1001.
  - Grant 3; then `rr`=0 and the next grant goes to 0.
- **Reset mid-flight:** two reads in flight; assert `rst_n`=0 for one cycle.
  - No `rd_valid` appears afterward.
  - `busy`=0 and `rr`=0 after release.
- **Idle:** `req`=0 for 10 cycles.
  - `mem_en`=0, `mem_addr`=0, `grant`=0, `rd_valid`=0.
  - `rr` unchanged.
